// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide unit. Operates on operand magnitudes, produces one
// product/quotient bit per clock over WIDTH iterations, then applies the sign in a final cycle.
module multdiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMult = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic               dz_q, dz_d;       // divisor was zero
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;   // {accumulator, remaining multiplier bits}
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   quo_s;

  // Operand magnitudes and the per-iteration datapath.
  always_comb begin
    a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    mult_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    // Top bit of the difference is the borrow: remainder stays below the divisor, so the
    // shifted partial remainder never reaches bit WIDTH+1.
    div_diff = {rem_q, quo_q[WIDTH-1]} - {2'b00, opnd_q};
    prod_s   = sign_q ? -prod_q : prod_q;
    prod_top = prod_s[2*WIDTH-1:WIDTH-1];
    quo_s    = sign_q ? -quo_q : quo_q;
  end

  // Next-state: a start pulse always wins and aborts whatever is in flight.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
    if (ctrl_MULT || ctrl_DIV) begin
      sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      cnt_d  = '0;
      dz_d   = (data_operandB == '0);
      if (ctrl_MULT) begin
        state_d = StMult;
        opnd_d  = a_mag;
        prod_d  = {{WIDTH{1'b0}}, b_mag};
      end else begin
        state_d = StDiv;
        opnd_d  = b_mag;
        quo_d   = a_mag;
        rem_d   = '0;
      end
    end else begin
      case (state_q)
        StMult: begin
          busy_d = 1'b1;
          if (cnt_q == LastCnt) begin
            state_d  = StDone;
            busy_d   = 1'b0;
            rdy_d    = 1'b1;
            result_d = prod_s[WIDTH-1:0];
            exc_d    = !((&prod_top) || !(|prod_top));
          end else begin
            prod_d = {mult_sum, prod_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CntW'(1);
          end
        end
        StDiv: begin
          busy_d = 1'b1;
          if (cnt_q == LastCnt) begin
            state_d  = StDone;
            busy_d   = 1'b0;
            rdy_d    = 1'b1;
            result_d = dz_q ? '0 : quo_s;
            // Only -2^(W-1) / -1 yields an unsigned quotient that overflows when positive.
            exc_d    = dz_q || (!sign_q && quo_q[WIDTH-1]);
          end else begin
            if (!div_diff[WIDTH+1]) begin
              rem_d = div_diff[WIDTH:0];
              quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
              quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: the driver queues expected results as it issues
// operations; the monitor checks every cycle against the queue and the held outputs.
module tb_multdiv_seq;

  localparam int unsigned W = 32;
  localparam int Latency = W + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           start;
    bit           chk_busy;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  multdiv_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
    end
  endfunction

  // Issue one start pulse; flush drops any expectation of an operation being aborted.
  task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input bit e, input bit chk, input bit flush);
    @(posedge clock); #1;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    if (flush) exp_q.delete();
    exp_q.push_back('{res: r, exc: e, start: cyc + 1, chk_busy: chk});
    @(posedge clock); #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(posedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rdy_timeout", W'(exp_q.size()), '0);
      exp_q.delete();
    end
    repeat (3) @(posedge clock);
  endtask

  // Monitor: pops on RDY, otherwise requires held outputs and no busy when nothing pending.
  initial begin
    logic [W-1:0] held_res = '0;
    logic         held_exc = 1'b0;
    int           busy_cnt = 0;
    exp_t         e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        held_res = '0;
        held_exc = 1'b0;
        busy_cnt = 0;
      end else if (data_resultRDY) begin
        if (exp_q.size() == 0) begin
          check("spurious_rdy", W'(data_resultRDY), '0);
        end else begin
          e = exp_q.pop_front();
          check("result", data_result, e.res);
          check("exception", W'(data_exception), W'(e.exc));
          check("latency", W'(cyc - e.start), W'(Latency));
          check("busy_at_rdy", W'(busy), '0);
          if (e.chk_busy) check("busy_cycles", W'(busy_cnt), W'(W));
          held_res = e.res;
          held_exc = e.exc;
        end
        busy_cnt = 0;
      end else begin
        check("hold_result", data_result, held_res);
        check("hold_exception", W'(data_exception), W'(held_exc));
        if (exp_q.size() == 0) check("idle_busy", W'(busy), '0);
        if (busy) busy_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (50) @(posedge clock);

    // Multiply cases.
    issue(1, 0, 32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFD6, 0, 1, 0); wait_done();
    issue(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 1, 0); wait_done();
    issue(1, 0, 32'h8000_0000, 32'd1,        32'h8000_0000, 0, 1, 0); wait_done();
    issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0); wait_done();
    // Hold check spans these idle cycles.
    repeat (10) @(posedge clock);

    // Divide cases.
    issue(0, 1, 32'hFFFF_FFD5, 32'd5,        32'hFFFF_FFF8, 0, 1, 0); wait_done();
    issue(0, 1, 32'd100,       32'd0,        32'h0000_0000, 1, 1, 0); wait_done();
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, 0); wait_done();
    issue(0, 1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 1, 0); wait_done();

    // Restart: DIV aborted by MULT 10 cycles later.
    issue(0, 1, 32'd1000, 32'd7, 32'd142, 0, 0, 0);
    repeat (8) @(posedge clock);
    issue(1, 0, 32'd3, 32'd4, 32'd12, 0, 0, 1); wait_done();

    // Both start pulses: multiply wins.
    issue(1, 1, 32'hFFFF_FFFB, 32'hFFFF_FFF7, 32'd45, 0, 1, 0); wait_done();

    // Reset mid-multiply: no RDY may follow.
    issue(1, 0, 32'd5, 32'd5, 32'd25, 0, 0, 0);
    repeat (18) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    @(posedge clock); #1 reset = 1'b1;
    repeat (50) @(posedge clock);

    issue(0, 1, 32'd9, 32'd2, 32'd4, 0, 1, 0); wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
